alu_exec: RTL and testbench
===========================

# alu_exec

Execution/write-back stage that sits directly upstream of the 8-bit combinational `alu`. It accepts 12-bit instructions over a valid/ready handshake, drives the ALU's `OP`/`A`/`R` inputs from an accumulator and a small register file, and registers `OUT`/`CY` back into the accumulator and carry flag. An OUT instruction presents the accumulator on a result handshake with backpressure.

## Interface
- `REG_COUNT`, 4, number of 8-bit general registers (power of two, 2..16); index `RI_W = $clog2(REG_COUNT)`
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `instr_valid`  in  1  instruction present
- `instr_ready`  out  1  stage can accept an instruction
- `instr_data`  in  12  [11:8] opcode, [7:0] operand (immediate, or register index in [RI_W-1:0])
- `alu_op`  out  4  to ALU `OP`
- `alu_a`  out  8  to ALU `A` (accumulator)
- `alu_r`  out  8  to ALU `R` (register or immediate)
- `alu_out`  in  8  from ALU `OUT`
- `alu_cy`  in  1  from ALU `CY`
- `res_valid`  out  1  result word present
- `res_ready`  in  1  consumer accepts result
- `res_data`  out  8  accumulator value snapshot
- `acc`  out  8  accumulator (debug/status)
- `flag_cy`, `flag_z`  out  1  carry and zero flags

## Operation
- Opcodes (bit 3 = immediate select, passed to ALU unchanged; ALU ignores bit 3):
  - 0x0 ADD, 0x1 SUB, 0x2 AND, 0x3 OR, 0x4 XOR, 0x5 NOT, 0x6 MOV A←R, 0x7 ST reg[idx]←A: R = reg[operand[RI_W-1:0]]
  - 0x8–0xE: same ALU ops with R = operand; 0xD = NOT, 0xE = LDI; 0xF = OUT
- States: IDLE, EXEC, EMIT.
  - IDLE: `instr_ready`=1; on `instr_valid&&instr_ready` latch `instr_data` into IR → EXEC.
  - EXEC: `alu_op`=IR[11:8], `alu_a`=A, `alu_r` per bit 3. End of cycle:
    - 0x0–0x6/0x8–0xE: A←`alu_out`; Z←(`alu_out`==0).
    - CY←`alu_cy` for ADD/SUB (SUB carry = borrow, 1 iff A<R); CY←0 for AND/OR/XOR/NOT; CY unchanged for MOV/LDI (ALU leaves CY undriven there; ignore it).
    - 0x7: reg[idx]←A; flags unchanged. → IDLE.
    - 0xF: `res_data`←A → EMIT.
  - EMIT: `res_valid`=1, `res_data` stable until `res_ready`=1 → IDLE.
- Register index out of range impossible (index is masked to RI_W bits).
- `alu_op`/`alu_a`/`alu_r` outside EXEC: drive IR-derived values anyway (no glitch requirement; only sampled in EXEC).

## Timing
- Reset (async assert, sync-to-clk deassert externally): state IDLE, IR=0, A=0, all regs=0, CY=0, Z=1, `res_valid`=0, `res_data`=0; `instr_ready`=1 immediately after deassert.
- ALU path is combinational: `alu_out` must settle within EXEC cycle (single-cycle path A/reg→ALU→A).
- ALU/ST latency: accepted at edge N, A/flags/reg updated at edge N+1, `instr_ready` high again after edge N+1; throughput 1 instruction / 2 cycles.
- OUT: `res_valid` rises after edge N+1; minimum 1 cycle in EMIT; `instr_ready`=0 throughout EMIT (full stall under backpressure).
- `instr_ready` depends only on state (no combinational path from `instr_valid` or `res_ready`).
- Back-to-back: ST followed by reg-source op reading same index sees the new value.
- Reset mid-EXEC/EMIT: instruction discarded, no write-back, `res_valid` drops asynchronously.

## Structure
- Package `alu_exec_pkg`: opcode constants (OPC_ADD..OPC_OUT), IMM bit position, state enum (IDLE/EXEC/EMIT), instruction field offsets.
- Sub-module `exec_regfile`: REG_COUNT×8 flops, one async read port, one write port, async active-low reset to 0.
- Top-level system wires `alu_exec` → `alu`; `alu_exec` does not instantiate the ALU.

## Test plan
- Reset, then 0xE0A (LDI) → A=0x0A, CY=0, Z=0 one edge after acceptance; `instr_ready` low exactly one cycle.
- A=0x0A, 0x902 (SUB #2) → A=0x08, CY=0; then 0x909 (SUB #9) → A=0xFF, CY=1, Z=0.
- A=0x08, 0x8FF (ADD #0xFF) → A=0x07, CY=1; then 0xE00 (LDI 0) → A=0x00, Z=1, CY still 1.
- 0x702 (ST r2) with A=0x3C, then 0xAF0 (AND #0xF0) → A=0x30, then 0x202 (AND r2) → A=0x30, CY=0; 0x602 (MOV r2) → A=0x3C.
- 0xF00 (OUT) with `res_ready` held low 5 cycles → `res_valid`=1, `res_data` constant, `instr_ready`=0; release → handshake, IDLE next cycle.
- Assert `rst_n` low during EXEC of 0x8FF and during EMIT → no A update, `res_valid`=0 immediately, all reset values restored.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// Shared definitions for the alu_exec execute/write-back stage.
// Covers opcodes, instruction field positions, FSM states and carry-update decoding.
package alu_exec_pkg;

    localparam int DATA_W  = 8;
    localparam int OPC_W   = 4;
    localparam int INSTR_W = 12;
    localparam int OPC_LSB = 8;
    localparam int OPD_LSB = 0;
    localparam int IMM_BIT = 3;

    localparam logic [OPC_W-1:0] OPC_ADD  = 4'h0;
    localparam logic [OPC_W-1:0] OPC_SUB  = 4'h1;
    localparam logic [OPC_W-1:0] OPC_AND  = 4'h2;
    localparam logic [OPC_W-1:0] OPC_OR   = 4'h3;
    localparam logic [OPC_W-1:0] OPC_XOR  = 4'h4;
    localparam logic [OPC_W-1:0] OPC_NOT  = 4'h5;
    localparam logic [OPC_W-1:0] OPC_MOV  = 4'h6;
    localparam logic [OPC_W-1:0] OPC_ST   = 4'h7;
    localparam logic [OPC_W-1:0] OPC_NOTI = 4'hD;
    localparam logic [OPC_W-1:0] OPC_LDI  = 4'hE;
    localparam logic [OPC_W-1:0] OPC_OUT  = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        EMIT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CY_KEEP = 2'd0,
        CY_ALU  = 2'd1,
        CY_CLR  = 2'd2
    } cy_mode_e;

    // The ALU ignores the immediate bit, so carry handling depends only on opcode[2:0].
    function automatic cy_mode_e cy_mode(input logic [OPC_W-1:0] opc);
        cy_mode_e m;
        case (opc[2:0])
            3'd0, 3'd1:             m = CY_ALU;
            3'd2, 3'd3, 3'd4, 3'd5: m = CY_CLR;
            default:                m = CY_KEEP;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/alu_exec_regfile.sv
// General register file for alu_exec: async read, single synchronous write port.
module exec_regfile
    import alu_exec_pkg::*;
#(
    parameter int REG_COUNT = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_we,
    input  logic [$clog2(REG_COUNT)-1:0] i_waddr,
    input  logic [DATA_W-1:0]            i_wdata,
    input  logic [$clog2(REG_COUNT)-1:0] i_raddr,
    output logic [DATA_W-1:0]            o_rdata
);

    logic [DATA_W-1:0] r_regs [REG_COUNT];

    // Register storage with write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_regs[i_raddr];

endmodule

// File: rtl/alu_exec.sv
// Execute/write-back stage feeding an external combinational 8-bit ALU.
// Accepts one instruction per two cycles; OUT presents the accumulator on a backpressured result port.
module alu_exec
    import alu_exec_pkg::*;
#(
    parameter int REG_COUNT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [INSTR_W-1:0]   instr_data,
    output logic [OPC_W-1:0]     alu_op,
    output logic [DATA_W-1:0]    alu_a,
    output logic [DATA_W-1:0]    alu_r,
    input  logic [DATA_W-1:0]    alu_out,
    input  logic                 alu_cy,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [DATA_W-1:0]    res_data,
    output logic [DATA_W-1:0]    acc,
    output logic                 flag_cy,
    output logic                 flag_z
);

    localparam int RI_W = $clog2(REG_COUNT);

    state_e              r_state;
    logic [INSTR_W-1:0]  r_ir;
    logic [DATA_W-1:0]   r_acc;
    logic                r_cy;
    logic                r_z;
    logic [DATA_W-1:0]   r_res_data;
    logic                r_res_valid;
    logic                r_instr_ready;

    logic [OPC_W-1:0]    w_opc;
    logic [DATA_W-1:0]   w_opd;
    logic [RI_W-1:0]     w_idx;
    logic [DATA_W-1:0]   w_reg_rdata;
    logic                w_reg_we;

    assign w_opc    = r_ir[OPC_LSB +: OPC_W];
    assign w_opd    = r_ir[OPD_LSB +: DATA_W];
    assign w_idx    = w_opd[RI_W-1:0];
    assign w_reg_we = (r_state == EXEC) && (w_opc == OPC_ST);

    exec_regfile #(
        .REG_COUNT (REG_COUNT)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_reg_we),
        .i_waddr (w_idx),
        .i_wdata (r_acc),
        .i_raddr (w_idx),
        .o_rdata (w_reg_rdata)
    );

    // Second ALU operand: immediate or register, chosen by the opcode's immediate bit.
    always_comb begin
        alu_r = w_reg_rdata;
        if (w_opc[IMM_BIT]) begin
            alu_r = w_opd;
        end else begin
            alu_r = w_reg_rdata;
        end
    end

    assign alu_op      = w_opc;
    assign alu_a       = r_acc;
    assign acc         = r_acc;
    assign flag_cy     = r_cy;
    assign flag_z      = r_z;
    assign res_data    = r_res_data;
    assign res_valid   = r_res_valid;
    assign instr_ready = r_instr_ready;

    // Stage FSM with accumulator/flag write-back and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_ir          <= 12'h000;
            r_acc         <= 8'h00;
            r_cy          <= 1'b0;
            r_z           <= 1'b1;
            r_res_data    <= 8'h00;
            r_res_valid   <= 1'b0;
            r_instr_ready <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (instr_valid) begin
                        r_ir          <= instr_data;
                        r_instr_ready <= 1'b0;
                        r_state       <= EXEC;
                    end
                end
                EXEC: begin
                    if (w_opc == OPC_OUT) begin
                        r_res_data  <= r_acc;
                        r_res_valid <= 1'b1;
                        r_state     <= EMIT;
                    end else begin
                        r_instr_ready <= 1'b1;
                        r_state       <= IDLE;
                        // ST writes the register file only; accumulator and flags hold.
                        if (w_opc != OPC_ST) begin
                            r_acc <= alu_out;
                            r_z   <= (alu_out == 8'h00);
                            case (cy_mode(w_opc))
                                CY_ALU:  r_cy <= alu_cy;
                                CY_CLR:  r_cy <= 1'b0;
                                default: r_cy <= r_cy;
                            endcase
                        end
                    end
                end
                EMIT: begin
                    if (res_ready) begin
                        r_res_valid   <= 1'b0;
                        r_instr_ready <= 1'b1;
                        r_state       <= IDLE;
                    end
                end
                default: begin
                    r_res_valid   <= 1'b0;
                    r_instr_ready <= 1'b1;
                    r_state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec with a behavioural ALU model wired to the ALU ports.
module tb_alu_exec;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [11:0] instr_data;
    logic [3:0]  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_r;
    logic [7:0]  alu_out;
    logic        alu_cy;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_data;
    logic [7:0]  acc;
    logic        flag_cy;
    logic        flag_z;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_exec #(.REG_COUNT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_data  (instr_data),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_r       (alu_r),
        .alu_out     (alu_out),
        .alu_cy      (alu_cy),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .acc         (acc),
        .flag_cy     (flag_cy),
        .flag_z      (flag_z)
    );

    // ALU model; MOV drives CY high so a stage that fails to ignore it is caught.
    always_comb begin
        logic [8:0] sum;
        sum     = {1'b0, alu_a} + {1'b0, alu_r};
        alu_out = 8'h00;
        alu_cy  = 1'b0;
        case (alu_op[2:0])
            3'd0: begin alu_out = sum[7:0]; alu_cy = sum[8]; end
            3'd1: begin alu_out = alu_a - alu_r; alu_cy = (alu_a < alu_r); end
            3'd2: alu_out = alu_a & alu_r;
            3'd3: alu_out = alu_a | alu_r;
            3'd4: alu_out = alu_a ^ alu_r;
            3'd5: alu_out = ~alu_a;
            3'd6: begin alu_out = alu_r; alu_cy = 1'b1; end
            default: begin alu_out = 8'hA5; alu_cy = 1'b1; end
        endcase
    end

    task automatic issue(input logic [11:0] d);
        instr_valid = 1'b1;
        instr_data  = d;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; instr_valid = 1'b0; instr_data = 12'h000; res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (acc !== 8'h00) begin errors++; $display("FAIL reset_acc got=%h exp=00", acc); end
        checks++; if (flag_z !== 1'b1 || flag_cy !== 1'b0) begin errors++; $display("FAIL reset_flags got z=%b cy=%b exp z=1 cy=0", flag_z, flag_cy); end
        checks++; if (res_valid !== 1'b0 || res_data !== 8'h00) begin errors++; $display("FAIL reset_res got v=%b d=%h exp v=0 d=00", res_valid, res_data); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", instr_ready); end
    endtask

    task automatic test_ldi();
        instr_valid = 1'b1; instr_data = 12'hE0A;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL ldi_ready_low got=%b exp=0", instr_ready); end
        checks++; if (acc !== 8'h00) begin errors++; $display("FAIL ldi_acc_early got=%h exp=00", acc); end
        @(posedge clk); #1;
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL ldi_ready_back got=%b exp=1", instr_ready); end
        checks++; if (acc !== 8'h0A || flag_cy !== 1'b0 || flag_z !== 1'b0) begin errors++; $display("FAIL ldi got acc=%h cy=%b z=%b exp 0a 0 0", acc, flag_cy, flag_z); end
    endtask

    task automatic test_sub();
        issue(12'h902);
        checks++; if (acc !== 8'h08 || flag_cy !== 1'b0 || flag_z !== 1'b0) begin errors++; $display("FAIL sub2 got acc=%h cy=%b z=%b exp 08 0 0", acc, flag_cy, flag_z); end
        issue(12'h909);
        checks++; if (acc !== 8'hFF || flag_cy !== 1'b1 || flag_z !== 1'b0) begin errors++; $display("FAIL sub9 got acc=%h cy=%b z=%b exp ff 1 0", acc, flag_cy, flag_z); end
    endtask

    task automatic test_add();
        issue(12'hE08);
        checks++; if (acc !== 8'h08 || flag_cy !== 1'b1) begin errors++; $display("FAIL ldi8 got acc=%h cy=%b exp 08 1", acc, flag_cy); end
        issue(12'h8FF);
        checks++; if (acc !== 8'h07 || flag_cy !== 1'b1 || flag_z !== 1'b0) begin errors++; $display("FAIL addff got acc=%h cy=%b z=%b exp 07 1 0", acc, flag_cy, flag_z); end
        issue(12'hE00);
        checks++; if (acc !== 8'h00 || flag_z !== 1'b1 || flag_cy !== 1'b1) begin errors++; $display("FAIL ldi0 got acc=%h z=%b cy=%b exp 00 1 1", acc, flag_z, flag_cy); end
    endtask

    task automatic test_regs();
        issue(12'hE3C);
        issue(12'h702);
        checks++; if (acc !== 8'h3C || flag_z !== 1'b0 || flag_cy !== 1'b1) begin errors++; $display("FAIL st_hold got acc=%h z=%b cy=%b exp 3c 0 1", acc, flag_z, flag_cy); end
        issue(12'hAF0);
        checks++; if (acc !== 8'h30 || flag_cy !== 1'b0) begin errors++; $display("FAIL andi got acc=%h cy=%b exp 30 0", acc, flag_cy); end
        issue(12'h202);
        checks++; if (acc !== 8'h30 || flag_cy !== 1'b0) begin errors++; $display("FAIL andr got acc=%h cy=%b exp 30 0", acc, flag_cy); end
        issue(12'h602);
        checks++; if (acc !== 8'h3C) begin errors++; $display("FAIL movr got acc=%h exp 3c", acc); end
    endtask

    task automatic test_back_to_back();
        issue(12'hE55);
        issue(12'h701);
        issue(12'hE00);
        // Operand 0xFD masks to register index 1.
        issue(12'h3FD);
        checks++; if (acc !== 8'h55 || flag_z !== 1'b0) begin errors++; $display("FAIL st_then_or got acc=%h z=%b exp 55 0", acc, flag_z); end
        issue(12'hC0F);
        checks++; if (acc !== 8'h5A || flag_cy !== 1'b0) begin errors++; $display("FAIL xori got acc=%h cy=%b exp 5a 0", acc, flag_cy); end
        issue(12'h602);
    endtask

    task automatic test_out();
        res_ready = 1'b0;
        issue(12'hF00);
        for (int i = 0; i < 5; i++) begin
            instr_valid = 1'b1; instr_data = 12'hE77;
            checks++; if (res_valid !== 1'b1 || res_data !== 8'h3C || instr_ready !== 1'b0) begin errors++; $display("FAIL out_stall%0d got v=%b d=%h rdy=%b exp 1 3c 0", i, res_valid, res_data, instr_ready); end
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0; res_ready = 1'b0;
        checks++; if (res_valid !== 1'b0 || instr_ready !== 1'b1) begin errors++; $display("FAIL out_release got v=%b rdy=%b exp 0 1", res_valid, instr_ready); end
        @(posedge clk); #1;
        checks++; if (acc !== 8'h3C || instr_ready !== 1'b1) begin errors++; $display("FAIL out_no_accept got acc=%h rdy=%b exp 3c 1", acc, instr_ready); end
    endtask

    task automatic test_reset_mid();
        int wait_cnt;
        issue(12'hE08);
        instr_valid = 1'b1; instr_data = 12'h8FF;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (acc !== 8'h00 || flag_z !== 1'b1 || flag_cy !== 1'b0 || instr_ready !== 1'b1) begin errors++; $display("FAIL rst_exec got acc=%h z=%b cy=%b rdy=%b exp 00 1 0 1", acc, flag_z, flag_cy, instr_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (acc !== 8'h00 || instr_ready !== 1'b1) begin errors++; $display("FAIL rst_exec_after got acc=%h rdy=%b exp 00 1", acc, instr_ready); end
        issue(12'h602);
        checks++; if (acc !== 8'h00 || flag_z !== 1'b1) begin errors++; $display("FAIL rst_regfile got acc=%h z=%b exp 00 1", acc, flag_z); end
        issue(12'hE5A);
        res_ready = 1'b0;
        instr_valid = 1'b1; instr_data = 12'hF00;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        wait_cnt = 0;
        while (res_valid !== 1'b1 && wait_cnt < 10) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        checks++; if (res_valid !== 1'b1 || res_data !== 8'h5A) begin errors++; $display("FAIL rst_emit_setup got v=%b d=%h exp 1 5a", res_valid, res_data); end
        rst_n = 1'b0;
        #1;
        checks++; if (res_valid !== 1'b0 || res_data !== 8'h00 || acc !== 8'h00 || instr_ready !== 1'b1) begin errors++; $display("FAIL rst_emit got v=%b d=%h acc=%h rdy=%b exp 0 00 00 1", res_valid, res_data, acc, instr_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (res_valid !== 1'b0 || instr_ready !== 1'b1) begin errors++; $display("FAIL rst_emit_after got v=%b rdy=%b exp 0 1", res_valid, instr_ready); end
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_sub();
        test_add();
        test_regs();
        test_back_to_back();
        test_out();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
